layer_result_formatter: RTL
===========================

# layer_result_formatter

Post-accumulation formatting stage of the multiply-add accelerator. It captures one vector of LANES signed accumulator results on a start pulse, then rounds, shifts, optionally ReLUs and saturates each lane to DATA_W bits over a fixed 3-cycle pipeline. It holds the formatted vector in a LANES-entry buffer. The layer controller then streams that buffer back one element per read-enable cycle as the next layer's operand (mux select "formatted_result").

## Interface
- LANES, 16, number of accumulator lanes and buffer depth (power of 2)
- ACC_W, 32, signed accumulator width per lane
- DATA_W, 8, signed formatted output width
- SHIFT_W, 5, width of the right-shift amount

- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start_i  input  1  start pulse; accepted only in IDLE
- acc_data_i  input  LANES*ACC_W  packed signed accumulators; lane k = bits [k*ACC_W +: ACC_W]
- shift_i  input  SHIFT_W  right-shift amount, captured with start
- relu_en_i  input  1  clamp negatives to 0, captured with start
- read_en_i  input  1  advance the buffer read pointer
- fmt_data_o  output  DATA_W  buffer entry at the read pointer (combinational from registers)
- fmt_valid_o  output  1  buffer holds a formatted vector
- busy_o  output  1  pipeline is in progress
- done_o  output  1  one-cycle pulse when the buffer is loaded
- ovf_o  output  1  sticky saturation flag for the current vector

## Operation
- States:
  - IDLE: start_i high → SHIFT. Latch all lanes, shift_i and relu_en_i. Clear ovf_o.
  - SHIFT: per lane, r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. Compute in ACC_W+1 bits so the rounding add cannot overflow. Rounding is half-up toward +inf. Register r → CLIP.
  - CLIP: per lane, if relu and r<0 then 0. Else saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register the result. Set ovf_o if any lane saturated; ReLU zeroing is not overflow → LOAD.
  - LOAD: write all lanes to the buffer. rd_ptr ← 0, fmt_valid_o ← 1, done_o pulse → IDLE.
- busy_o = 1 in SHIFT, CLIP and LOAD.
- start_i outside IDLE is ignored; nothing is queued.
- Reads:
  - fmt_data_o = buf[rd_ptr] when fmt_valid_o, else 0.
  - read_en_i with fmt_valid_o=1 → rd_ptr+1 mod LANES. Wrap-around keeps the contents, so the buffer can be re-read.
  - read_en_i with fmt_valid_o=0 is ignored.
  - During busy, reads continue from the previous vector.
  - read_en_i coinciding with the LOAD write: the load wins, rd_ptr = 0.
- fmt_valid_o stays 1 from the first LOAD until reset.

## Timing
- Reset: synchronous. It overrides every other input at the edge.
  - State → IDLE; buffer and pipeline registers → 0.
  - rd_ptr, fmt_valid_o, busy_o, done_o, ovf_o → 0.
  - fmt_data_o → 0.
  - Reset mid-pipeline aborts the operation with no done_o.
- start_i sampled at edge E0. busy_o is high after E0 through E2.
- LOAD executes at edge E3: buffer written, done_o and the new fmt_data_o (lane 0) visible in the cycle after E3. Latency is 3 cycles from the start edge to the result.
- ovf_o updates at E2 and holds until the next accepted start.
- A new start is accepted no earlier than edge E4; this gives back-to-back vectors every 4 cycles.
- One read per cycle. The first read_en edge after done moves fmt_data_o from lane 0 to lane 1.

## Test plan
- Reset: hold rst_n=0 with start_i=1 and read_en_i=1. Required: all outputs 0. After release, state is IDLE and the first start gives done_o 3 cycles after the start edge.
- Basic shift: lane k acc = k*256, shift=8, relu=0. Required: done_o after 3 cycles; 16 reads give 0,1,…,15; the 17th read returns 0 (wrap); ovf_o=0.
- Rounding:
  - acc=384, shift=8 → 2
  - acc=-384, shift=8 → -1
  - acc=-385, shift=8 → -2
  - acc=127, shift=0 → 127
- Saturation and ReLU:
  - acc=0x7FFFFFFF, shift=1 → 127 with ovf_o=1; checks the widened rounding add.
  - acc=-1000, shift=0 → -128 with ovf_o=1.
  - Same vector with relu=1 → 0. If no other lane saturates, ovf_o=0.
- Busy collisions:
  - Start again at E1 and E2 → ignored; exactly one done_o.
  - Reads during busy return the old vector.
  - read_en_i at E3 → rd_ptr=0 and lane 0 of the new vector is shown.
- Reset mid-operation: rst_n=0 at E1. Required: no done_o, fmt_valid_o=0, buffer reads 0, and a following start completes normally.

Source files
------------

// File: rtl/layer_result_formatter.sv
// Post-accumulation formatter: rounds, shifts, optionally ReLUs and saturates a
// vector of accumulator lanes over a 3-stage pipeline, then serves it from a read buffer.
module layer_result_formatter #(
  parameter int LANES   = 16,
  parameter int ACC_W   = 32,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [LANES*ACC_W-1:0]   acc_data_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  input  logic                     relu_en_i,
  input  logic                     read_en_i,
  output logic [DATA_W-1:0]        fmt_data_o,
  output logic                     fmt_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o
);

  localparam int PTR_W = $clog2(LANES);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CLIP = 2'd2, LOAD = 2'd3} state_t;

  state_t                    state_r, state_s;
  logic signed [ACC_W-1:0]   acc_r   [LANES];
  logic signed [ACC_W:0]     rnd_r   [LANES];
  logic [DATA_W-1:0]         clip_r  [LANES];
  logic [DATA_W-1:0]         fmt_buf [LANES];
  logic [DATA_W:0]           clip_s  [LANES];
  logic [SHIFT_W-1:0]        shift_r;
  logic                      relu_r;
  logic                      any_sat_s;
  logic                      fmt_valid_r, done_r, ovf_r;
  logic [PTR_W-1:0]          rd_ptr_r;

  // Widened by one bit so the half-up rounding add can never wrap.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] acc,
                                                         input logic [SHIFT_W-1:0] sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    ext = {acc[ACC_W-1], acc};
    rnd = '0;
    if (sh != '0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - {{(SHIFT_W-1){1'b0}}, 1'b1});
    end else begin
      rnd = '0;
    end
    return (ext + rnd) >>> sh;
  endfunction

  // Returns {saturated, value}; ReLU zeroing is not reported as saturation.
  function automatic logic [DATA_W:0] clip(input logic signed [ACC_W:0] r, input logic relu);
    logic [DATA_W:0] res;
    if (relu && r[ACC_W]) begin
      res = '0;
    end else if (r > SAT_MAX) begin
      res = {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (r < SAT_MIN) begin
      res = {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      res = {1'b0, r[DATA_W-1:0]};
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_i) state_s = SHIFT; else state_s = IDLE;
      SHIFT:   state_s = CLIP;
      CLIP:    state_s = LOAD;
      LOAD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Per-lane clip stage and overflow reduction.
  always_comb begin
    any_sat_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      clip_s[k] = clip(rnd_r[k], relu_r);
      any_sat_s = any_sat_s | clip_s[k][DATA_W];
    end
  end

  // Capture, round/shift, clip and buffer-load pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        acc_r[k]   <= '0;
        rnd_r[k]   <= '0;
        clip_r[k]  <= '0;
        fmt_buf[k] <= '0;
      end
      shift_r     <= '0;
      relu_r      <= 1'b0;
      ovf_r       <= 1'b0;
      done_r      <= 1'b0;
      fmt_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < LANES; k++) acc_r[k] <= acc_data_i[k*ACC_W +: ACC_W];
            shift_r <= shift_i;
            relu_r  <= relu_en_i;
            ovf_r   <= 1'b0;
          end
        end
        SHIFT: for (int k = 0; k < LANES; k++) rnd_r[k] <= round_shift(acc_r[k], shift_r);
        CLIP: begin
          for (int k = 0; k < LANES; k++) clip_r[k] <= clip_s[k][DATA_W-1:0];
          ovf_r <= any_sat_s;
        end
        LOAD: begin
          for (int k = 0; k < LANES; k++) fmt_buf[k] <= clip_r[k];
          fmt_valid_r <= 1'b1;
          done_r      <= 1'b1;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  // Read pointer; a buffer load takes priority over a coincident read.
  always_ff @(posedge clk) begin
    if (!rst_n)                         rd_ptr_r <= '0;
    else if (state_r == LOAD)           rd_ptr_r <= '0;
    else if (read_en_i && fmt_valid_r)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    else                                rd_ptr_r <= rd_ptr_r;
  end

  assign fmt_data_o  = fmt_valid_r ? fmt_buf[rd_ptr_r] : '0;
  assign fmt_valid_o = fmt_valid_r;
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;
  assign ovf_o       = ovf_r;

endmodule
